// File: rtl/spi_pkg.sv
// Shared types for the SPI register-access sequencer: FSM states, the 16-bit
// frame layout and small constant helpers.
package spi_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SEND,
    WAIT_RX,
    HOLD,
    RESP,
    GAP
  } spi_ra_state_e;

  localparam int FRAME_W        = 16;
  localparam int FRAME_RW_BIT   = 15;
  localparam int FRAME_ADDR_MSB = 14;
  localparam int FRAME_ADDR_LSB = 8;
  localparam int FRAME_DATA_MSB = 7;
  localparam int FRAME_DATA_LSB = 0;

  typedef struct packed {
    logic       rw;
    logic [6:0] addr;
    logic [7:0] data;
  } spi_frame_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Reads carry a zero data byte so the slave sees a clean command word.
  function automatic spi_frame_t pack_frame(input logic       wr,
                                            input logic [6:0] addr,
                                            input logic [7:0] wdata,
                                            input logic       read_bit);
    spi_frame_t f;
    f.rw   = wr ? ~read_bit : read_bit;
    f.addr = addr;
    f.data = wr ? wdata : 8'h00;
    return f;
  endfunction

endpackage

// File: rtl/spi_cycle_timer.sv
// Loadable down-counter shared by every timed sequencer state; it stops at
// zero instead of wrapping.
module spi_cycle_timer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] value,
  output logic             done
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign value = cnt_q;
  assign done  = (cnt_q == '0);

endmodule

// File: rtl/spi_reg_access.sv
// Host-side register access sequencer in front of the 16-bit SPI master:
// frames one read/write at a time and frames it with chip-select timing.
//
// state   | meaning
// IDLE    | cs_n high, waiting for a host request
// SETUP   | cs_n low, counting chip-select setup
// SEND    | frame offered to the master until it is taken
// WAIT_RX | waiting for the received word or the timeout
// HOLD    | cs_n still low, counting chip-select hold
// RESP    | response presented to the host
// GAP     | cs_n high, enforced idle time before the next request
module spi_reg_access
  import spi_pkg::*;
#(
  parameter int   CS_SETUP_CYC = 4,
  parameter int   CS_HOLD_CYC  = 4,
  parameter int   GAP_CYC      = 8,
  parameter int   TIMEOUT_CYC  = 1024,
  parameter logic READ_BIT_VAL = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wr,
  input  logic [6:0]  req_addr,
  input  logic [7:0]  req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [7:0]  rsp_rdata,
  output logic        rsp_err,
  output logic        m_valid,
  input  logic        m_ready,
  output logic [15:0] m_data,
  input  logic        m_rvalid,
  input  logic [15:0] m_rdata,
  output logic        cs_n
);

  localparam int MAX_CYC = max_int(max_int(CS_SETUP_CYC, CS_HOLD_CYC),
                                   max_int(GAP_CYC, TIMEOUT_CYC));
  localparam int TMR_W   = $clog2(MAX_CYC + 1);

  spi_ra_state_e state_q, state_d;
  spi_frame_t    frame_q, frame_d;
  logic          cs_n_q, cs_n_d;
  logic          m_valid_q, m_valid_d;
  logic [15:0]   m_data_q, m_data_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic [7:0]    rsp_rdata_q, rsp_rdata_d;
  logic          rsp_err_q, rsp_err_d;

  logic             tmr_load;
  logic [TMR_W-1:0] tmr_load_val;
  logic [TMR_W-1:0] tmr_value_unused;
  logic             tmr_done;
  logic             rx_hi_unused;

  assign rx_hi_unused = ^m_rdata[FRAME_W-1:FRAME_DATA_MSB+1];

  spi_cycle_timer #(
    .WIDTH (TMR_W)
  ) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (tmr_load_val),
    .value    (tmr_value_unused),
    .done     (tmr_done)
  );

  always_comb begin
    state_d      = state_q;
    frame_d      = frame_q;
    cs_n_d       = cs_n_q;
    m_valid_d    = m_valid_q;
    m_data_d     = m_data_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_rdata_d  = rsp_rdata_q;
    rsp_err_d    = rsp_err_q;
    tmr_load     = 1'b0;
    tmr_load_val = '0;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          frame_d      = pack_frame(req_wr, req_addr, req_wdata, READ_BIT_VAL);
          rsp_rdata_d  = 8'h00;
          rsp_err_d    = 1'b0;
          cs_n_d       = 1'b0;
          tmr_load     = 1'b1;
          // Timed states load N-1 so that the state lasts exactly N cycles.
          tmr_load_val = TMR_W'(CS_SETUP_CYC - 1);
          state_d      = SETUP;
        end
      end
      SETUP: begin
        if (tmr_done) begin
          m_valid_d = 1'b1;
          m_data_d  = frame_q;
          state_d   = SEND;
        end
      end
      SEND: begin
        if (m_ready) begin
          m_valid_d    = 1'b0;
          tmr_load     = 1'b1;
          tmr_load_val = TMR_W'(TIMEOUT_CYC);
          state_d      = WAIT_RX;
        end
      end
      WAIT_RX: begin
        // A word arriving on the terminal-count cycle still counts as a reply.
        if (m_rvalid) begin
          rsp_rdata_d  = (frame_q.rw == READ_BIT_VAL) ?
                         m_rdata[FRAME_DATA_MSB:FRAME_DATA_LSB] : 8'h00;
          rsp_err_d    = 1'b0;
          tmr_load     = 1'b1;
          tmr_load_val = TMR_W'(CS_HOLD_CYC - 1);
          state_d      = HOLD;
        end else if (tmr_done) begin
          rsp_rdata_d  = 8'h00;
          rsp_err_d    = 1'b1;
          tmr_load     = 1'b1;
          tmr_load_val = TMR_W'(CS_HOLD_CYC - 1);
          state_d      = HOLD;
        end
      end
      HOLD: begin
        if (tmr_done) begin
          cs_n_d      = 1'b1;
          rsp_valid_d = 1'b1;
          state_d     = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d  = 1'b0;
          tmr_load     = 1'b1;
          tmr_load_val = TMR_W'(GAP_CYC - 1);
          state_d      = GAP;
        end
      end
      GAP: begin
        if (tmr_done) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      frame_q     <= '0;
      cs_n_q      <= 1'b1;
      m_valid_q   <= 1'b0;
      m_data_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      frame_q     <= frame_d;
      cs_n_q      <= cs_n_d;
      m_valid_q   <= m_valid_d;
      m_data_q    <= m_data_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign req_ready = (state_q == IDLE);
  assign cs_n      = cs_n_q;
  assign m_valid   = m_valid_q;
  assign m_data    = m_data_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_spi_reg_access.sv
// Self-checking bench for spi_reg_access: a scoreboard of expected frames and
// responses, plus cycle counts for chip-select setup, hold, gap and timeout.
module tb_spi_reg_access;

  localparam int   T_SETUP = 4;
  localparam int   T_HOLD  = 4;
  localparam int   T_GAP   = 8;
  localparam int   T_TO    = 1024;
  localparam logic RB      = 1'b1;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_wr;
  logic [6:0]  req_addr;
  logic [7:0]  req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [7:0]  rsp_rdata;
  logic        rsp_err;
  logic        m_valid;
  logic        m_ready;
  logic [15:0] m_data;
  logic        m_rvalid;
  logic [15:0] m_rdata;
  logic        cs_n;

  logic [15:0] exp_frame_q[$];
  logic [8:0]  exp_rsp_q[$];

  int n_chk  = 0;
  int n_fail = 0;

  spi_reg_access #(
    .CS_SETUP_CYC (T_SETUP),
    .CS_HOLD_CYC  (T_HOLD),
    .GAP_CYC      (T_GAP),
    .TIMEOUT_CYC  (T_TO),
    .READ_BIT_VAL (RB)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_wr    (req_wr),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data),
    .m_rvalid  (m_rvalid),
    .m_rdata   (m_rdata),
    .cs_n      (cs_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: compare frames and responses at the handshake edges.
  always @(negedge clk) begin
    if (rst_n) begin
      if (m_valid && m_ready) begin
        if (exp_frame_q.size() == 0) chk("frame_unexpected", 1, 0);
        else chk("m_data", m_data, exp_frame_q.pop_front());
      end
      if (rsp_valid && rsp_ready) begin
        if (exp_rsp_q.size() == 0) chk("rsp_unexpected", 1, 0);
        else chk("rsp_err_rdata", {rsp_err, rsp_rdata}, exp_rsp_q.pop_front());
      end
    end
  end

  task automatic do_xfer(input logic wr, input logic [6:0] addr, input logic [7:0] wdata,
                         input logic [15:0] rx_word, input bit give_rx, input int rx_delay,
                         input int ready_delay, input int rsp_hold, input int exp_gap);
    logic [15:0] fr;
    logic [8:0]  rs;
    int          cnt;
    bit          ok;
    fr = {(wr ? ~RB : RB), addr, (wr ? wdata : 8'h00)};
    rs = give_rx ? {1'b0, (wr ? 8'h00 : rx_word[7:0])} : 9'h100;
    exp_frame_q.push_back(fr);
    exp_rsp_q.push_back(rs);
    m_ready   = (ready_delay == 0);
    rsp_ready = (rsp_hold == 0);
    req_valid = 1'b1;
    req_wr    = wr;
    req_addr  = addr;
    req_wdata = wdata;
    cnt = 0;
    while (!req_ready && cnt < 100) begin
      cnt++;
      cyc();
    end
    if (exp_gap >= 0) chk("gap_cycles", cnt, exp_gap);
    cyc();
    req_valid = 1'b0;
    cnt = 0;
    for (int i = 0; i < 50 && !m_valid; i++) begin
      if (!cs_n) cnt++;
      cyc();
    end
    chk("setup_cycles", cnt, T_SETUP);
    ok = 1'b1;
    for (int i = 0; i < ready_delay; i++) begin
      if (!m_valid || m_data !== fr) ok = 1'b0;
      cyc();
    end
    if (ready_delay > 0) chk("m_data_stable", ok, 1);
    m_ready = 1'b1;
    cyc();
    chk("m_valid_drop", m_valid, 0);
    if (give_rx) begin
      repeat (rx_delay) cyc();
      m_rvalid = 1'b1;
      m_rdata  = rx_word;
      cyc();
      m_rvalid = 1'b0;
      m_rdata  = 16'h0000;
      cnt = 0;
      for (int i = 0; i < 50 && !rsp_valid; i++) begin
        if (!cs_n) cnt++;
        cyc();
      end
      chk("hold_cycles", cnt, T_HOLD);
    end else begin
      cnt = 0;
      while (!rsp_valid && cnt < T_TO + 100) begin
        cnt++;
        cyc();
      end
      chk("timeout_cycles", cnt, T_TO + 1 + T_HOLD);
    end
    chk("cs_n_at_rsp", cs_n, 1);
    ok = 1'b1;
    for (int i = 0; i < rsp_hold; i++) begin
      if (!rsp_valid || {rsp_err, rsp_rdata} !== rs) ok = 1'b0;
      cyc();
    end
    if (rsp_hold > 0) chk("rsp_stable", ok, 1);
    rsp_ready = 1'b1;
    cyc();
    chk("rsp_valid_drop", rsp_valid, 0);
  endtask

  task automatic do_abort(input bit in_wait);
    int cnt;
    bit ok;
    m_ready   = in_wait;
    rsp_ready = 1'b1;
    if (in_wait) exp_frame_q.push_back({RB, 7'h11, 8'h00});
    req_valid = 1'b1;
    req_wr    = 1'b0;
    req_addr  = 7'h11;
    req_wdata = 8'h99;
    cnt = 0;
    while (!req_ready && cnt < 100) begin
      cnt++;
      cyc();
    end
    cyc();
    req_valid = 1'b0;
    cnt = 0;
    while (!m_valid && cnt < 50) begin
      cnt++;
      cyc();
    end
    repeat (2) cyc();
    chk(in_wait ? "pre_reset_cs_n_wait" : "pre_reset_cs_n_send", cs_n, 0);
    rst_n = 1'b0;
    cyc();
    chk("abort_cs_n", cs_n, 1);
    chk("abort_m_valid", m_valid, 0);
    chk("abort_rsp_valid", rsp_valid, 0);
    chk("abort_req_ready", req_ready, 1);
    rst_n   = 1'b1;
    m_ready = 1'b0;
    m_rvalid = 1'b1;
    m_rdata  = 16'h5555;
    cyc();
    m_rvalid = 1'b0;
    m_rdata  = 16'h0000;
    ok = 1'b1;
    repeat (20) begin
      if (rsp_valid || !cs_n || m_valid) ok = 1'b0;
      cyc();
    end
    chk("no_rsp_after_reset", ok, 1);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_wr    = 1'b0;
    req_addr  = 7'h00;
    req_wdata = 8'h00;
    rsp_ready = 1'b0;
    m_ready   = 1'b0;
    m_rvalid  = 1'b0;
    m_rdata   = 16'h0000;
    repeat (2) cyc();
    chk("rst_cs_n", cs_n, 1);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_data", m_data, 16'h0000);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_rdata", rsp_rdata, 8'h00);
    chk("rst_rsp_err", rsp_err, 0);
    chk("rst_req_ready", req_ready, 1);
    rst_n = 1'b1;
    cyc();

    do_xfer(1'b1, 7'h12, 8'hA5, 16'h0000, 1'b1, 2, 3, 0, 0);
    do_xfer(1'b0, 7'h7F, 8'h00, 16'hBEEF, 1'b1, 4, 0, 0, T_GAP);
    do_xfer(1'b0, 7'h05, 8'h3C, 16'h0000, 1'b0, 0, 0, 0, T_GAP);

    // Stray receive pulse after the timeout must produce nothing.
    m_rvalid = 1'b1;
    m_rdata  = 16'hFFFF;
    cyc();
    m_rvalid = 1'b0;
    m_rdata  = 16'h0000;
    ok = 1'b1;
    repeat (15) begin
      if (rsp_valid || !cs_n) ok = 1'b0;
      cyc();
    end
    chk("stray_rvalid_ignored", ok, 1);

    do_xfer(1'b1, 7'h33, 8'h5A, 16'h0000, 1'b1, 1, 0, 10, -1);
    do_xfer(1'b0, 7'h44, 8'h00, 16'h1234, 1'b1, 0, 0, 0, T_GAP);

    do_abort(1'b0);
    do_abort(1'b1);

    do_xfer(1'b0, 7'h2A, 8'h00, 16'hC3C3, 1'b1, T_TO, 0, 0, 0);
    do_xfer(1'b1, 7'h00, 8'hFF, 16'h0000, 1'b1, 0, 0, 0, T_GAP);

    chk("frames_consumed", exp_frame_q.size(), 0);
    chk("rsps_consumed", exp_rsp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_reg_access.md
Name: spi_reg_access

Overview:
- Register-access sequencer that sits directly upstream of the 16-bit SPI master.
- Accepts single-register read/write requests from a host, packs each into a 16-bit frame {rw, addr[6:0], data[7:0]}, and hands it to the master over its valid/ready input.
- Drives chip-select with programmable setup, hold and inter-frame gap, and captures the master's 16-bit received word.
- Returns read data or timeout status to the host over a valid/ready response channel.

Parameters:
- CS_SETUP_CYC, 4, clk cycles cs_n is low before the frame is offered to the master (>=1)
- CS_HOLD_CYC, 4, clk cycles cs_n stays low after the last bit is received (>=1)
- GAP_CYC, 8, clk cycles cs_n stays high after a response before the next request is accepted (>=1)
- TIMEOUT_CYC, 1024, max clk cycles from frame handoff to m_rvalid before abort (>=2)
- READ_BIT_VAL, 1, value of frame bit 15 that marks a read

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- req_valid  in  1  host request valid
- req_ready  out  1  high only in IDLE
- req_wr  in  1  1=write, 0=read
- req_addr  in  7  register address
- req_wdata  in  8  write data (ignored for reads)
- rsp_valid  out  1  response valid, held until rsp_ready
- rsp_ready  in  1  host accepts response
- rsp_rdata  out  8  read data; 0 for writes and on timeout
- rsp_err  out  1  1 = timeout
- m_valid  out  1  frame valid to SPI master
- m_ready  in  1  SPI master ready
- m_data  out  16  frame to SPI master
- m_rvalid  in  1  one-cycle pulse: master finished receiving 16 bits
- m_rdata  in  16  word received by master
- cs_n  out  1  SPI chip select, active low

Behaviour:
- One clock domain (clk). Reset is synchronous and active-low on rst_n. All outputs are registered.
- Reset values: cs_n=1, m_valid=0, m_data=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, state=IDLE. req_ready is decoded from state, so it is 1 from the first cycle after reset.
- Reset mid-operation: cs_n returns high on the next edge; the in-flight frame is dropped; no response is generated.
- States and transitions:
  - IDLE: on req_valid&req_ready, latch the frame and go to SETUP.
    - Frame bit15 = READ_BIT_VAL for reads, ~READ_BIT_VAL for writes.
    - Frame [14:8] = req_addr; [7:0] = req_wdata for writes, 0x00 for reads.
  - SETUP: cs_n=0 from the first SETUP cycle. Stay exactly CS_SETUP_CYC cycles, then go to SEND.
  - SEND: m_valid=1 and m_data = latched frame, held stable until m_valid&m_ready. On that edge, m_valid drops next cycle, the timeout counter loads TIMEOUT_CYC, and the state goes to WAIT_RX.
  - WAIT_RX:
    - On m_rvalid: capture m_rdata[7:0] for reads (0 for writes), err=0, go to HOLD.
    - If the counter reaches 0 first: rdata=0, err=1, go to HOLD.
    - If m_rvalid coincides with the terminal count, m_rvalid wins (err=0).
  - HOLD: cs_n=0 for CS_HOLD_CYC cycles, then cs_n=1 and go to RESP.
  - RESP: rsp_valid=1 with rsp_rdata/rsp_err stable. On rsp_valid&rsp_ready, go to GAP.
  - GAP: cs_n=1 for GAP_CYC cycles, then go to IDLE.
- m_rvalid outside WAIT_RX is ignored.
- m_ready is not required to be high in IDLE.
- One outstanding transaction at a time; no request queueing.
- Minimum request-to-response latency (write, m_ready already high, m_rvalid after N cycles): 1 + CS_SETUP_CYC + 1 + N + CS_HOLD_CYC cycles to rsp_valid.
- Counters: a single shared down-counter sized $clog2(max(all *_CYC)+1); it never wraps and saturates at 0.

Decomposition:
- Package spi_pkg holds:
  - state enum spi_ra_state_e (IDLE, SETUP, SEND, WAIT_RX, HOLD, RESP, GAP)
  - packed struct spi_frame_t {rw, addr[6:0], data[7:0]}
  - localparams for the frame field positions
- One sub-module, spi_cycle_timer: loadable saturating down-counter with load/value/done. Width is a parameter. It is reused for all timed states.

Test Plan:
- Write addr=0x12 data=0xA5, READ_BIT_VAL=1 -> m_data=0x12A5 held until m_ready; cs_n low exactly 4 cycles before m_valid; rsp_rdata=0x00, rsp_err=0.
- Read addr=0x7F, master model returns m_rdata=0xBEEF -> m_data=0xFF00; rsp_rdata=0xEF, rsp_err=0; cs_n high 4 cycles after m_rvalid.
- Read with m_rvalid never asserted -> after 1024 cycles in WAIT_RX, rsp_err=1, rsp_rdata=0x00; a later stray m_rvalid is ignored.
- Back-to-back requests with rsp_ready held low 10 cycles -> rsp_valid and data stable for 10 cycles; req_ready stays low until GAP (8 cycles) completes; second frame is correct.
- rst_n low for 1 cycle mid-SEND and mid-WAIT_RX -> next cycle cs_n=1, m_valid=0, rsp_valid=0, req_ready=1; no response emitted.
- m_rvalid on the same cycle the timeout expires -> rsp_err=0 and the captured data is returned.
